// File: rtl/dir_input.sv
// dir_input: button front end for the snake CPU.
// Synchronises and debounces the four direction buttons, turns each clean
// press into a direction change (reversals rejected) and presents the result
// as the status byte {flag, 5'b0, dir} read by the CPU at data address 255.
module dir_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       ack,
  output logic [7:0] out
);

  localparam int unsigned    NBTN     = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Direction codes
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_t;

  // Button bit order doubles as press priority: up > down > left > right
  logic [NBTN-1:0] raw_c;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] stable;
  logic [NBTN-1:0] stable_n;
  logic [NBTN-1:0] stable_q;
  logic [NBTN-1:0] press_c;

  db_state_t        state   [NBTN];
  db_state_t        state_n [NBTN];
  logic [CNT_W-1:0] cnt     [NBTN];
  logic [CNT_W-1:0] cnt_n   [NBTN];

  logic       flag;
  logic [1:0] dir;
  logic       cand_valid_c;
  logic [1:0] cand_dir_c;
  logic       accept_c;

  assign raw_c = {right, left, down, up};

  // Two-flop synchroniser per button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
    end
  end

  // Debouncer state register: FSM, counters, stable level and its delayed copy
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        state[i] <= ST_STABLE;
        cnt[i]   <= '0;
      end
      stable   <= '0;
      stable_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NBTN; i++) begin
        state[i] <= state_n[i];
        cnt[i]   <= cnt_n[i];
      end
      stable   <= stable_n;
      stable_q <= stable;
    end
  end

  // Debouncer next state: any cycle agreeing with the stable level restarts the count
  always_comb begin
    stable_n = stable;
    for (int unsigned i = 0; i < NBTN; i++) begin
      state_n[i] = state[i];
      cnt_n[i]   = cnt[i];
      case (state[i])
        ST_STABLE: begin
          if (sync2[i] != stable[i]) begin
            state_n[i] = ST_COUNTING;
            cnt_n[i]   = CNT_W'(1);
          end else begin
            cnt_n[i]   = '0;
          end
        end
        ST_COUNTING: begin
          if (sync2[i] == stable[i]) begin
            state_n[i] = ST_STABLE;
            cnt_n[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            stable_n[i] = sync2[i];
            state_n[i]  = ST_STABLE;
            cnt_n[i]    = '0;
          end else begin
            cnt_n[i]    = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_n[i] = ST_STABLE;
          cnt_n[i]   = '0;
        end
      endcase
    end
  end

  // Rising edge of the debounced level is a press; releases are ignored
  assign press_c = stable & ~stable_q;

  // Pick the single highest-priority press of this cycle
  always_comb begin
    cand_valid_c = 1'b0;
    cand_dir_c   = DIR_UP;
    if (press_c[0]) begin
      cand_valid_c = 1'b1;
      cand_dir_c   = DIR_UP;
    end else if (press_c[1]) begin
      cand_valid_c = 1'b1;
      cand_dir_c   = DIR_DOWN;
    end else if (press_c[2]) begin
      cand_valid_c = 1'b1;
      cand_dir_c   = DIR_LEFT;
    end else if (press_c[3]) begin
      cand_valid_c = 1'b1;
      cand_dir_c   = DIR_RIGHT;
    end
  end

  // A reversal (opposite = dir ^ 2'b10) is rejected; same direction still re-flags
  assign accept_c = cand_valid_c && (cand_dir_c != (dir ^ 2'b10));

  // Direction and new-press flag; an accepted press beats a same-cycle ack
  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= 1'b0;
      dir  <= DIR_RIGHT;
    end else if (accept_c) begin
      flag <= 1'b1;
      dir  <= cand_dir_c;
    end else if (ack) begin
      flag <= 1'b0;
    end
  end

  assign out = {flag, 5'b00000, dir};

endmodule

// File: tb/tb_dir_input.sv
// Directed bench for dir_input with a short debounce window (N = 4).
module tb_dir_input;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = 3;

  logic       clk;
  logic       reset;
  logic       up;
  logic       down;
  logic       left;
  logic       right;
  logic       ack;
  logic [7:0] out;

  int n_checks = 0;
  int n_pass   = 0;

  dir_input #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .up   (up),
    .down (down),
    .left (left),
    .right(right),
    .ack  (ack),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    else
      n_pass++;
  endtask

  // One clock edge, then settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // btn = {right, left, down, up}
  task automatic set_btn(input logic [3:0] b);
    up    = b[0];
    down  = b[1];
    left  = b[2];
    right = b[3];
  endtask

  task automatic do_reset(input logic [3:0] b);
    set_btn(b);
    reset = 1'b1;
    ack   = 1'b1;
    wait_n(2);
    check("reset_out", out, 8'h01);
    reset = 1'b0;
    ack   = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ack   = 1'b0;
    set_btn(4'b0000);

    // 1: reset with all buttons held; nothing before N+3 edges, then up wins
    do_reset(4'b1111);
    for (int e = 1; e <= N + 2; e++) begin
      tick();
      check("t1_hold", out, 8'h01);
    end
    tick();
    check("t1_first", out, 8'h80);

    // 2: clean press of up, then ack; holding gives no further press
    do_reset(4'b0000);
    set_btn(4'b0001);
    for (int e = 1; e <= N + 2; e++) begin
      tick();
      check("t2_wait", out, 8'h01);
    end
    tick();
    check("t2_press", out, 8'h80);
    ack_pulse();
    check("t2_ack", out, 8'h00);
    wait_n(2 * N);
    check("t2_held", out, 8'h00);

    // 3: bounce on left from dir=up, then a steady high
    do_reset(4'b0000);
    set_btn(4'b0001);
    wait_n(N + 3);
    check("t3_up", out, 8'h80);
    set_btn(4'b0000);
    wait_n(N + 3);
    ack_pulse();
    check("t3_ack", out, 8'h00);
    for (int i = 0; i < 10; i++) begin
      set_btn((i % 2 == 0) ? 4'b0100 : 4'b0000);
      tick();
      check("t3_bounce", out, 8'h00);
    end
    set_btn(4'b0100);
    for (int e = 1; e <= N + 2; e++) begin
      tick();
      check("t3_settle", out, 8'h00);
    end
    tick();
    check("t3_left", out, 8'h83);

    // 4: reversals rejected
    do_reset(4'b0000);
    set_btn(4'b0100);
    wait_n(N + 3);
    check("t4_left_rej", out, 8'h01);
    set_btn(4'b0000);
    wait_n(N + 3);
    set_btn(4'b0001);
    wait_n(N + 3);
    check("t4_up", out, 8'h80);
    set_btn(4'b0000);
    wait_n(N + 3);
    set_btn(4'b0010);
    wait_n(N + 3);
    check("t4_down_rej", out, 8'h80);
    set_btn(4'b0000);
    wait_n(N + 3);
    ack_pulse();
    check("t4_ack", out, 8'h00);
    set_btn(4'b0010);
    wait_n(N + 3);
    check("t4_down_rej2", out, 8'h00);

    // 5: up and right debounced together; only up applies
    do_reset(4'b0000);
    set_btn(4'b1001);
    wait_n(N + 2);
    check("t5_wait", out, 8'h01);
    tick();
    check("t5_up", out, 8'h80);
    wait_n(2 * N);
    check("t5_no_right", out, 8'h80);

    // 6: ack on the edge a down press is accepted; press wins
    do_reset(4'b0000);
    set_btn(4'b0010);
    wait_n(N + 2);
    check("t6_wait", out, 8'h01);
    ack_pulse();
    check("t6_collide", out, 8'h82);
    ack_pulse();
    check("t6_ack", out, 8'h02);

    // 7: reset in mid-count restarts the debounce
    do_reset(4'b0000);
    set_btn(4'b0001);
    wait_n(4);
    reset = 1'b1;
    tick();
    check("t7_rst", out, 8'h01);
    reset = 1'b0;
    wait_n(N + 2);
    check("t7_wait", out, 8'h01);
    tick();
    check("t7_up", out, 8'h80);

    // 8: glitch of N-1 cycles never reaches stable
    do_reset(4'b0000);
    set_btn(4'b0010);
    wait_n(N - 1);
    set_btn(4'b0000);
    wait_n(2 * N);
    check("t8_glitch", out, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
